// File: rtl/byte_order_swapper_pkg.sv
// Shared types and constants for the byte order swapper block.
// Mode encoding matches the 2-bit mode input driven by the bus side.
package byte_order_swapper_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        MODE_BYTE_REV  = 2'b00,
        MODE_HALF_SWAP = 2'b01,
        MODE_BIT_REV   = 2'b10,
        MODE_PASS      = 2'b11
    } mode_e;

endpackage

// File: rtl/byte_order_mux.sv
// Combinational word remapper: byte reverse, halfword swap, bit reverse or passthrough.
// Every mapping is pure wiring, so all four candidates are built and one is selected.
module byte_order_mux
    import byte_order_swapper_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  mode_e            mode,
    output logic [WIDTH-1:0] out
);

    localparam int NUM_BYTES  = WIDTH / BYTE_W;
    localparam int NUM_HALVES = WIDTH / HALF_W;

    logic [WIDTH-1:0] byte_rev;
    logic [WIDTH-1:0] half_swap;
    logic [WIDTH-1:0] bit_rev;

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
        assign byte_rev[k*BYTE_W +: BYTE_W] = in[(NUM_BYTES-1-k)*BYTE_W +: BYTE_W];
    end

    // Halfword order is reversed while bytes inside each halfword stay put.
    for (genvar h = 0; h < NUM_HALVES; h++) begin : g_half
        assign half_swap[h*HALF_W +: HALF_W] = in[(NUM_HALVES-1-h)*HALF_W +: HALF_W];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bit_rev[i] = in[WIDTH-1-i];
    end

    always_comb begin
        out = in;
        case (mode)
            MODE_BYTE_REV:  out = byte_rev;
            MODE_HALF_SWAP: out = half_swap;
            MODE_BIT_REV:   out = bit_rev;
            MODE_PASS:      out = in;
            default:        out = in;
        endcase
    end

endmodule

// File: rtl/byte_order_swapper.sv
// Registered endianness converter: one word per cycle, result visible the cycle after capture.
// Output holds its last value when no valid word arrives; out_valid follows in_valid.
module byte_order_swapper
    import byte_order_swapper_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out
);

    mode_e            mode_sel;
    logic [WIDTH-1:0] swapped;

    logic [WIDTH-1:0] out_d, out_q;
    logic             out_valid_d, out_valid_q;

    assign mode_sel = mode_e'(mode);

    byte_order_mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in   (in),
        .mode (mode_sel),
        .out  (swapped)
    );

    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = swapped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= RESET_VAL;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_byte_order_swapper.sv
// Self-checking bench for byte_order_swapper: directed plan vectors plus a randomized
// stream compared against an arithmetic reference model of the four mappings.
module tb_byte_order_swapper;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  mode;
    logic [31:0] in;
    logic        out_valid;
    logic [31:0] out;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_out   = 32'h0;
    logic        exp_valid = 1'b0;

    byte_order_swapper #(
        .WIDTH     (32),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .in        (in),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each mapping computed from shifts and masks on the whole word.
    function automatic logic [31:0] refModel(input logic [1:0] m, input logic [31:0] d);
        logic [31:0] r;
        r = 32'h0;
        case (m)
            2'b00: for (int k = 0; k < 4; k++)
                       r = r | (((d >> (8*k)) & 32'hFF) << (8*(3-k)));
            2'b01: r = (d << 16) | (d >> 16);
            2'b10: for (int i = 0; i < 32; i++)
                       if (d[i]) r = r | (32'h1 << (31-i));
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] eo, input logic ev);
        compared++;
        assert (out === eo) else begin
            mismatched++;
            $error("[TB] FAIL %s out observed=%h expected=%h", tag, out, eo);
        end
        compared++;
        assert (out_valid === ev) else begin
            mismatched++;
            $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, out_valid, ev);
        end
    endtask

    // Drive one cycle of inputs, let the DUT capture, then check at the falling edge.
    task automatic applyStimulus(input string tag, input logic v, input logic [1:0] m,
                                 input logic [31:0] d);
        in_valid = v;
        mode     = m;
        in       = d;
        @(posedge clk);
        if (!rst_n) begin
            exp_out   = 32'h0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = v;
            if (v) exp_out = refModel(m, d);
        end
        @(negedge clk);
        checkOutput(tag, exp_out, exp_valid);
    endtask

    task automatic checkConst(input string tag, input logic [31:0] eo, input logic ev);
        checkOutput(tag, eo, ev);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        mode     = 2'b00;
        in       = 32'hFFFF_FFFF;

        applyStimulus("reset_hold0", 1'b1, 2'b00, 32'hFFFF_FFFF);
        applyStimulus("reset_hold1", 1'b1, 2'b11, 32'hFFFF_FFFF);
        checkConst("reset_const", 32'h0, 1'b0);
        rst_n = 1'b1;

        applyStimulus("m00_w0", 1'b1, 2'b00, 32'hb1f05663);
        checkConst("m00_w0_c", 32'h6356f0b1, 1'b1);
        applyStimulus("m00_w1", 1'b1, 2'b00, 32'hc0895e81);
        checkConst("m00_w1_c", 32'h815e89c0, 1'b1);
        applyStimulus("m00_w2", 1'b1, 2'b00, 32'h46df998d);
        checkConst("m00_w2_c", 32'h8d99df46, 1'b1);
        applyStimulus("m00_w3", 1'b1, 2'b00, 32'h8484d609);
        checkConst("m00_w3_c", 32'h09d68484, 1'b1);

        applyStimulus("narrow", 1'b1, 2'b00, 32'h0000_5663);
        checkConst("narrow_c", 32'h6356_0000, 1'b1);

        applyStimulus("m01", 1'b1, 2'b01, 32'h1234_5678);
        checkConst("m01_c", 32'h5678_1234, 1'b1);
        applyStimulus("m10", 1'b1, 2'b10, 32'h1234_5678);
        checkConst("m10_c", 32'h1E6A_2C48, 1'b1);
        applyStimulus("m11", 1'b1, 2'b11, 32'h1234_5678);
        checkConst("m11_c", 32'h1234_5678, 1'b1);

        applyStimulus("hold_valid", 1'b1, 2'b00, 32'hA1B2C3D4);
        checkConst("hold_valid_c", 32'hD4C3B2A1, 1'b1);
        applyStimulus("hold_idle0", 1'b0, 2'b01, 32'h5555_AAAA);
        checkConst("hold_idle0_c", 32'hD4C3B2A1, 1'b0);
        applyStimulus("hold_idle1", 1'b0, 2'b10, 32'h0F0F_F0F0);
        checkConst("hold_idle1_c", 32'hD4C3B2A1, 1'b0);

        // Asynchronous reset between edges while a valid word is presented.
        applyStimulus("mid_pre", 1'b1, 2'b01, 32'hDEAD_BEEF);
        in_valid = 1'b1;
        in       = 32'hCAFE_F00D;
        #2;
        rst_n = 1'b0;
        #1;
        exp_out   = 32'h0;
        exp_valid = 1'b0;
        checkConst("mid_async", 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_held", exp_out, exp_valid);
        rst_n = 1'b1;
        applyStimulus("mid_after", 1'b1, 2'b00, 32'h0102_0304);
        checkConst("mid_after_c", 32'h0403_0201, 1'b1);

        for (int n = 0; n < 40; n++) begin
            applyStimulus("random", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
